// File: rtl/tt6581_pkg.sv
// -----------------------------------------------------------------------------
// tt6581_pkg
// Shared SPI register-port constants and the SPI slave FSM state type.
//   SPI_ADDR_W    : register address width carried in the command byte
//   SPI_DATA_W    : register data width carried in the data byte
//   SPI_FRAME_LEN : bits per SPI frame (1 R/W bit + address + data)
// -----------------------------------------------------------------------------
package tt6581_pkg;

  localparam int SPI_ADDR_W    = 7;
  localparam int SPI_DATA_W    = 8;
  localparam int SPI_FRAME_LEN = 16;

  // Bit counter wide enough to hold 0..SPI_FRAME_LEN.
  localparam int CNT_W = $clog2(SPI_FRAME_LEN + 1);

  // Counter value seen when the last command bit (R/W + address) arrives.
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(SPI_ADDR_W);
  // Counter value seen when the last data bit arrives.
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(SPI_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, both flops load RST_VAL
//   d_i    : asynchronous input
//   q_o    : synchronized output (two clk_i cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 slave giving an SPI master access to the voice/filter register
// file. Frame (MSB first): bit15 = 1 write / 0 read, bits14:8 address,
// bits7:0 data. sclk/cs/mosi are oversampled by clk_i, so each sclk
// half-period must last at least 4 clk_i cycles.
//
// Ports
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   sclk_i   : SPI clock (async)
//   cs_i     : chip select, active low (async)
//   mosi_i   : serial data in
//   miso_o   : serial data out (read data, readback builds only)
//   addr_o   : register address of the current frame
//   wdata_o  : write data, valid while wr_en_o = 1
//   wr_en_o  : one-cycle write strobe
//   rd_en_o  : one-cycle read request (readback builds only)
//   rdata_i  : read data, valid the cycle after rd_en_o
//
// Build option
//   SPI_READBACK_EN : when defined, read frames issue rd_en_o and shift the
//                     returned byte out on miso_o. When undefined, rd_en_o and
//                     miso_o are tied low and read frames finish silently.
// -----------------------------------------------------------------------------
module spi_slave
  import tt6581_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  cs_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [SPI_ADDR_W-1:0] addr_o,
  output logic [SPI_DATA_W-1:0] wdata_o,
  output logic                  wr_en_o,
  output logic                  rd_en_o,
  input  logic [SPI_DATA_W-1:0] rdata_i
);

  logic sclk_s, cs_s, mosi_s;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i), .q_o(sclk_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),   .q_o(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .d_i(mosi_i), .q_o(mosi_s));

  spi_state_e            state_q;
  logic                  sclk_prev_q;
  logic                  cs_prev_q;
  logic [1:0]            settle_q;
  logic                  armed_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [SPI_DATA_W-1:0] rx_q;
  logic                  is_wr_q;
  logic [SPI_ADDR_W-1:0] addr_q;
  logic [SPI_DATA_W-1:0] wdata_q;
  logic                  wr_en_q;
`ifdef SPI_READBACK_EN
  logic                  rd_en_q;
  logic                  load_q;
  logic [SPI_DATA_W-1:0] tx_q;
  logic                  miso_q;
`endif

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_en_q     <= 1'b0;
      load_q      <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
`endif
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      wr_en_q     <= 1'b0;

      // The synchronizers show their reset value for two cycles after reset.
      // Only a cs level seen after that is trusted to arm the slave, so a cs
      // already low at reset release never looks like a new frame.
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && cs_s) armed_q <= 1'b1;

`ifdef SPI_READBACK_EN
      // rd_en_o -> rdata_i valid one cycle later -> captured into tx_q.
      rd_en_q <= 1'b0;
      load_q  <= rd_en_q;
      if (load_q) tx_q <= rdata_i;
`endif

      if (cs_rise) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
`ifdef SPI_READBACK_EN
        miso_q  <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall && armed_q) begin
              state_q <= ST_CMD;
              cnt_q   <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_q  <= {rx_q[SPI_DATA_W-2:0], mosi_s};
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_CMD_LAST) begin
                // rx_q still holds the first 7 bits: R/W flag then addr[6:1].
                is_wr_q <= rx_q[SPI_ADDR_W-1];
                addr_q  <= {rx_q[SPI_ADDR_W-2:0], mosi_s};
                state_q <= ST_DATA;
`ifdef SPI_READBACK_EN
                if (!rx_q[SPI_ADDR_W-1]) rd_en_q <= 1'b1;
`endif
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx_q  <= {rx_q[SPI_DATA_W-2:0], mosi_s};
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_FRAME_LAST) begin
                state_q <= ST_DONE;
                if (is_wr_q) begin
                  wdata_q <= {rx_q[SPI_DATA_W-2:0], mosi_s};
                  wr_en_q <= 1'b1;
                end
`ifdef SPI_READBACK_EN
                miso_q <= 1'b0;
`endif
              end
`ifdef SPI_READBACK_EN
            end else if (sclk_fall && !is_wr_q) begin
              // First falling edge in DATA is the 8th of the frame: bit7 out.
              miso_q <= tx_q[SPI_DATA_W-1];
              tx_q   <= {tx_q[SPI_DATA_W-2:0], 1'b0};
`endif
            end
          end
          ST_DONE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign wr_en_o = wr_en_q;

`ifdef SPI_READBACK_EN
  assign rd_en_o = rd_en_q;
  assign miso_o  = miso_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;
  assign rd_en_o      = 1'b0;
  assign miso_o       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed and randomized SPI frames driven by a behavioural SPI master; the
// expected register-port activity of each frame is derived from the frame
// word, the number of bits clocked and whether the slave was armed.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  logic       clk_i;
  logic       rst_i;
  logic       sclk_i;
  logic       cs_i;
  logic       mosi_i;
  logic       miso_o;
  logic [6:0] addr_o;
  logic [7:0] wdata_o;
  logic       wr_en_o;
  logic       rd_en_o;
  logic [7:0] rdata_i;

  spi_slave dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sclk_i  (sclk_i),
    .cs_i    (cs_i),
    .mosi_i  (mosi_i),
    .miso_o  (miso_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .wr_en_o (wr_en_o),
    .rd_en_o (rd_en_o),
    .rdata_i (rdata_i)
  );

  // 50 MHz system clock.
  initial clk_i = 1'b0;
  always #10 clk_i = ~clk_i;

  localparam int HP     = 12; // ~2 MHz sclk
  localparam int HP_MIN = 4;

`ifdef SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [14:0] wr_q[$];
  logic [6:0]  rd_q[$];
  int          both_cnt   = 0;
  int          miso_bad   = 0;
  bit          miso_allow = 1'b0;

  // Bus monitor: records every strobe and any miso activity outside a read
  // data phase.
  always @(negedge clk_i) begin
    if (wr_en_o === 1'b1) wr_q.push_back({addr_o, wdata_o});
    if (rd_en_o === 1'b1) rd_q.push_back(addr_o);
    if (wr_en_o === 1'b1 && rd_en_o === 1'b1) both_cnt++;
    if (miso_o !== 1'b0 && !miso_allow) miso_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SPI mode-0 master. Drives nbits of word (MSB first, random filler after
  // 16 bits); returns the miso bits it sampled on rises 9..16.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, input int hp,
                          input bit start_cs, input bit raise_cs, output logic [7:0] rx);
    rx = '0;
    if (start_cs) begin
      @(negedge clk_i);
      cs_i = 1'b0;
      repeat (hp) @(negedge clk_i);
    end
    for (int b = 0; b < nbits; b++) begin
      mosi_i = (b < 16) ? word[15-b] : 1'($urandom_range(0, 1));
      if (READBACK && !word[15] && b >= 8) miso_allow = 1'b1;
      repeat (hp) @(negedge clk_i);
      sclk_i = 1'b1;
      if (b >= 8 && b < 16) rx = {rx[6:0], miso_o};
      repeat (hp) @(negedge clk_i);
      sclk_i = 1'b0;
    end
    repeat (hp) @(negedge clk_i);
    if (raise_cs) begin
      cs_i = 1'b1;
      repeat (2 * hp + 4) @(negedge clk_i);
      miso_allow = 1'b0;
    end
  endtask

  // Reference model: what a frame of nbits bits of word must produce.
  task automatic check_frame(input string tag, input logic [15:0] word, input int nbits,
                             input bit armed, input logic [7:0] rx_obs, input logic [7:0] rdv);
    int          exp_wr_n;
    int          exp_rd_n;
    logic [7:0]  exp_rx;
    bit          full;
    full     = (nbits >= 16);
    exp_wr_n = (armed && full && word[15]) ? 1 : 0;
    exp_rd_n = (READBACK && armed && nbits >= 8 && !word[15]) ? 1 : 0;
    exp_rx   = (exp_rd_n == 1 && full) ? rdv : 8'h00;
    chk({tag, "_wr_cnt"}, 32'(wr_q.size()), 32'(exp_wr_n));
    if (exp_wr_n == 1 && wr_q.size() == 1)
      chk({tag, "_wr_addr_data"}, 32'(wr_q[0]), 32'({word[14:8], word[7:0]}));
    chk({tag, "_rd_cnt"}, 32'(rd_q.size()), 32'(exp_rd_n));
    if (exp_rd_n == 1 && rd_q.size() == 1)
      chk({tag, "_rd_addr"}, 32'(rd_q[0]), 32'(word[14:8]));
    if (full) chk({tag, "_miso_bits"}, 32'(rx_obs), 32'(exp_rx));
    chk({tag, "_miso_idle"}, 32'(miso_bad), 32'd0);
    wr_q.delete();
    rd_q.delete();
    miso_bad = 0;
  endtask

  initial begin
    logic [7:0]  rx;
    logic [15:0] w;
    logic [7:0]  rd;
    int          n;

    rst_i   = 1'b1;
    sclk_i  = 1'b0;
    cs_i    = 1'b1;
    mosi_i  = 1'b0;
    rdata_i = 8'h00;
    repeat (5) @(negedge clk_i);
    chk("rst_addr",  32'(addr_o),  32'h0);
    chk("rst_wdata", 32'(wdata_o), 32'h0);
    chk("rst_wr_en", 32'(wr_en_o), 32'h0);
    chk("rst_rd_en", 32'(rd_en_o), 32'h0);
    chk("rst_miso",  32'(miso_o),  32'h0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);

    // Plain write.
    spi_xfer(16'h8A5C, 16, HP, 1'b1, 1'b1, rx);
    check_frame("wr_8A5C", 16'h8A5C, 16, 1'b1, rx, rdata_i);

    // Read with readback data 0xC3.
    rdata_i = 8'hC3;
    spi_xfer(16'h1500, 16, HP, 1'b1, 1'b1, rx);
    check_frame("rd_1500", 16'h1500, 16, 1'b1, rx, 8'hC3);

    // Aborted write after 11 bits, then a full write.
    spi_xfer(16'h8AFF, 11, HP, 1'b1, 1'b1, rx);
    check_frame("wr_abort", 16'h8AFF, 11, 1'b1, rx, rdata_i);
    spi_xfer(16'h8B01, 16, HP, 1'b1, 1'b1, rx);
    check_frame("wr_8B01", 16'h8B01, 16, 1'b1, rx, rdata_i);

    // Write followed by 8 extra sclk pulses while cs stays low.
    spi_xfer(16'h8A5C, 24, HP, 1'b1, 1'b1, rx);
    check_frame("wr_extra", 16'h8A5C, 24, 1'b1, rx, rdata_i);

    // Minimum sclk half-period, back-to-back writes.
    spi_xfer(16'h8001, 16, HP_MIN, 1'b1, 1'b1, rx);
    check_frame("wr_min_8001", 16'h8001, 16, 1'b1, rx, rdata_i);
    spi_xfer(16'h8102, 16, HP_MIN, 1'b1, 1'b1, rx);
    check_frame("wr_min_8102", 16'h8102, 16, 1'b1, rx, rdata_i);

    // Reset pulsed at bit 6 of a write with cs held low.
    spi_xfer(16'h8A5C, 6, HP, 1'b1, 1'b0, rx);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_addr",  32'(addr_o),  32'h0);
    chk("midrst_wdata", 32'(wdata_o), 32'h0);
    chk("midrst_wr_en", 32'(wr_en_o), 32'h0);
    chk("midrst_miso",  32'(miso_o),  32'h0);
    w = 16'(($urandom() & 32'h7FFF) | 32'h8000);
    spi_xfer(w, 10, HP, 1'b0, 1'b1, rx);
    check_frame("midrst_tail", w, 10, 1'b0, rx, rdata_i);
    spi_xfer(16'h8C33, 16, HP, 1'b1, 1'b1, rx);
    check_frame("midrst_next", 16'h8C33, 16, 1'b1, rx, rdata_i);

    // Randomized frames: mixed reads/writes, some aborted.
    for (int i = 0; i < 24; i++) begin
      w       = 16'($urandom());
      rd      = 8'($urandom());
      rdata_i = rd;
      n       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      spi_xfer(w, n, HP, 1'b1, 1'b1, rx);
      check_frame("rand", w, n, 1'b1, rx, rd);
    end

    chk("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have one clock, clk_i; reset is synchronous and active-high, rst_i.
REQ-002 clk_i  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 sclk_i  input  1  SPI clock, asynchronous to clk_i, mode 0 (CPOL=0, CPHA=0).
REQ-005 cs_i  input  1  chip select, active low, asynchronous.
REQ-006 mosi_i  input  1  serial data in, MSB first.
REQ-007 miso_o  output  1  serial data out, MSB first.
REQ-008 addr_o  output  7  register address of the current frame.
REQ-009 wdata_o  output  8  write data, valid while wr_en_o=1.
REQ-010 wr_en_o  output  1  one-cycle write strobe to the voice/filter register file.
REQ-011 rd_en_o  output  1  one-cycle read request.
REQ-012 rdata_i  input  8  read data, SHALL be valid in the cycle after rd_en_o.

Function
REQ-013 sclk_i, cs_i and mosi_i SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected from the synchronized value, with 3 clk_i cycles of total latency.
REQ-014 Legal operation SHALL require each sclk half-period to be at least 4 clk_i cycles.
REQ-015 Frame: 16 bits; bit15 = 1 write / 0 read, bits14:8 address, bits7:0 data.
REQ-016 mosi SHALL be sampled on synchronized sclk rising edges and miso SHALL be updated on falling edges.
REQ-017 FSM states: IDLE, CMD (bits 15..8), DATA (bits 7..0), DONE.
REQ-018 Transition IDLE->CMD SHALL occur on synchronized cs falling edge; bit counter SHALL clear.
REQ-019 Transition CMD->DATA SHALL occur after the 8th rising edge; addr_o SHALL latch at that edge.
REQ-020 On read, rd_en_o SHALL pulse for one cycle on the cycle after the 8th rising edge; rdata_i SHALL load the TX shift register one cycle later; miso_o SHALL present bit7 from the 8th falling edge.
REQ-021 Transition DATA->DONE SHALL occur after the 16th rising edge; on write, wr_en_o SHALL pulse for one cycle with wdata_o/addr_o stable in that cycle.
REQ-022 In DONE, further sclk edges SHALL be ignored until cs rises; there SHALL be no second strobe.
REQ-023 A cs rise in any state SHALL return the FSM to IDLE; a partial frame SHALL produce no wr_en_o.
REQ-024 miso_o SHALL be 0 in IDLE, CMD, DONE and during write frames.
REQ-025 wr_en_o and rd_en_o SHALL never both be 1 in the same cycle.

Reset
REQ-026 On rst_i: FSM=IDLE, counter=0, shift registers=0, addr_o=0, wdata_o=0, wr_en_o=0, rd_en_o=0, miso_o=0.
REQ-027 If cs is already low when rst_i deasserts, the frame SHALL be ignored until a cs rise then fall is seen.
REQ-028 Synchronizer flops SHALL also reset to cs=1, sclk=0, mosi=0.

Configuration
REQ-029 Macro SPI_READBACK_EN: when defined, reads SHALL follow REQ-020.
REQ-030 When SPI_READBACK_EN is undefined, rd_en_o SHALL tie to 0, miso_o SHALL tie to 0, rdata_i SHALL be unused, and read frames SHALL complete with no strobe.

Structure
REQ-031 Package tt6581_pkg SHALL hold SPI_ADDR_W=7, SPI_DATA_W=8, SPI_FRAME_LEN=16 and the FSM state enum typedef.
REQ-032 Sub-module sync_2ff (1-bit, reset value parameter) SHALL be instantiated three times.

Verification (clk 50 MHz, sclk 2 MHz unless noted)
REQ-033 Write frame 0x8A5C (addr 0x0A, data 0x5C) -> exactly one wr_en_o pulse, addr_o=0x0A, wdata_o=0x5C.
REQ-034 Read frame 0x1500 with rdata_i=0xC3 -> one rd_en_o pulse with addr_o=0x15; bits sampled by the master on sclk rise = 1100_0011.
REQ-035 cs raised after 11 bits of write 0x8AFF, then a full write 0x8B01 -> no strobe for the first frame, one strobe with addr 0x0B/data 0x01 for the second.
REQ-036 Write 0x8A5C followed by 8 extra sclk pulses -> single wr_en_o only.
REQ-037 rst_i pulsed at bit 6 of a write frame, cs held low -> outputs at reset values, no strobe until a cs rise then a new frame.
REQ-038 sclk half-period = 4 clk_i cycles (minimum), back-to-back writes 0x8001 and 0x8102 -> both strobes correct; with SPI_READBACK_EN undefined, read 0x1500 -> miso_o=0 throughout and no rd_en_o.
